fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 139 +++++++++++++
 tb/tb_fetch_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the fetch and decode stages.
// Holds up to DEPTH {instruction, PC+4} pairs; every output is registered.
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic [WIDTH-1:0]         InInstruction,
   input  logic [WIDTH-1:0]         InPCPlus4,
   input  logic                     InValid,
   output logic                     InReady,
   output logic [WIDTH-1:0]         OutInstruction,
   output logic [WIDTH-1:0]         OutPCPlus4,
   output logic                     OutValid,
   input  logic                     OutReady,
   input  logic                     Flush,
   output logic [$clog2(DEPTH):0]   Count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   // Pointer advance; the power-of-two depth makes the wrap implicit.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      return ptr + PTR_W'(1);
   endfunction

   logic [WIDTH-1:0] instr_mem_r [DEPTH];
   logic [WIDTH-1:0] pc_mem_r    [DEPTH];
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             in_ready_r;
   logic             out_valid_r;
   logic [WIDTH-1:0] out_instr_r;
   logic [WIDTH-1:0] out_pc_r;

   logic             push_s;
   logic             pop_s;
   logic [PTR_W-1:0] rd_ptr_nxt_s;
   logic [PTR_W-1:0] wr_ptr_nxt_s;
   logic [CNT_W-1:0] count_nxt_s;
   logic [WIDTH-1:0] head_instr_nxt_s;
   logic [WIDTH-1:0] head_pc_nxt_s;

   // Handshakes only look at registered flags, so OutReady never reaches InReady.
   assign push_s = InValid && in_ready_r && !Flush;
   assign pop_s  = out_valid_r && OutReady && !Flush;

   // Next pointers and occupancy; a flush overrides any concurrent push or pop.
   always_comb begin
      rd_ptr_nxt_s = rd_ptr_r;
      wr_ptr_nxt_s = wr_ptr_r;
      count_nxt_s  = count_r;
      if (Flush) begin
         rd_ptr_nxt_s = {PTR_W{1'b0}};
         wr_ptr_nxt_s = {PTR_W{1'b0}};
         count_nxt_s  = {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
         end else begin
            wr_ptr_nxt_s = wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
         end else begin
            rd_ptr_nxt_s = rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
         endcase
      end
   end

   // Head for the next cycle; the slot being written this edge is bypassed from the input.
   always_comb begin
      head_instr_nxt_s = {WIDTH{1'b0}};
      head_pc_nxt_s    = {WIDTH{1'b0}};
      if (count_nxt_s == {CNT_W{1'b0}}) begin
         head_instr_nxt_s = {WIDTH{1'b0}};
         head_pc_nxt_s    = {WIDTH{1'b0}};
      end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
         head_instr_nxt_s = InInstruction;
         head_pc_nxt_s    = InPCPlus4;
      end else begin
         head_instr_nxt_s = instr_mem_r[rd_ptr_nxt_s];
         head_pc_nxt_s    = pc_mem_r[rd_ptr_nxt_s];
      end
   end

   // Entry storage, cleared only by reset.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            instr_mem_r[i] <= {WIDTH{1'b0}};
            pc_mem_r[i]    <= {WIDTH{1'b0}};
         end
      end else if (push_s) begin
         instr_mem_r[wr_ptr_r] <= InInstruction;
         pc_mem_r[wr_ptr_r]    <= InPCPlus4;
      end else begin
         instr_mem_r[wr_ptr_r] <= instr_mem_r[wr_ptr_r];
         pc_mem_r[wr_ptr_r]    <= pc_mem_r[wr_ptr_r];
      end
   end

   // Control state and registered outputs.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         rd_ptr_r    <= {PTR_W{1'b0}};
         wr_ptr_r    <= {PTR_W{1'b0}};
         count_r     <= {CNT_W{1'b0}};
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         out_instr_r <= {WIDTH{1'b0}};
         out_pc_r    <= {WIDTH{1'b0}};
      end else begin
         rd_ptr_r    <= rd_ptr_nxt_s;
         wr_ptr_r    <= wr_ptr_nxt_s;
         count_r     <= count_nxt_s;
         in_ready_r  <= (count_nxt_s < DEPTH_C);
         out_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
         out_instr_r <= head_instr_nxt_s;
         out_pc_r    <= head_pc_nxt_s;
      end
   end

   assign InReady        = in_ready_r;
   assign OutValid       = out_valid_r;
   assign OutInstruction = out_instr_r;
   assign OutPCPlus4     = out_pc_r;
   assign Count          = count_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_fetch_queue;

   localparam int DEPTH = 4;
   localparam int WIDTH = 32;

   logic             Clock;
   logic             Reset;
   logic [WIDTH-1:0] InInstruction;
   logic [WIDTH-1:0] InPCPlus4;
   logic             InValid;
   logic             InReady;
   logic [WIDTH-1:0] OutInstruction;
   logic [WIDTH-1:0] OutPCPlus4;
   logic             OutValid;
   logic             OutReady;
   logic             Flush;
   logic [2:0]       Count;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [63:0] mq[$];
   logic             exp_valid;
   logic             exp_ready;
   logic [2:0]       exp_count;
   logic [WIDTH-1:0] exp_instr;
   logic [WIDTH-1:0] exp_pc;

   fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .Clock(Clock), .Reset(Reset),
      .InInstruction(InInstruction), .InPCPlus4(InPCPlus4),
      .InValid(InValid), .InReady(InReady),
      .OutInstruction(OutInstruction), .OutPCPlus4(OutPCPlus4),
      .OutValid(OutValid), .OutReady(OutReady),
      .Flush(Flush), .Count(Count)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Drive one cycle, advance the model by the queue rules, settle past the edge.
   task automatic step(input logic [31:0] i, input logic [31:0] p,
                       input logic v, input logic r, input logic f);
      bit do_pop;
      bit do_push;
      logic [63:0] dummy;
      InInstruction = i; InPCPlus4 = p; InValid = v; OutReady = r; Flush = f;
      @(posedge Clock);
      if (f) begin
         mq.delete();
      end else begin
         do_pop  = (mq.size() > 0) && r;
         do_push = v && (mq.size() < DEPTH);
         if (do_pop) dummy = mq.pop_front();
         if (do_push) mq.push_back({i, p});
      end
      #1;
   endtask

   task automatic model_expect();
      exp_valid = (mq.size() > 0);
      exp_ready = (mq.size() < DEPTH);
      exp_count = 3'(mq.size());
      exp_instr = (mq.size() > 0) ? mq[0][63:32] : 32'h0;
      exp_pc    = (mq.size() > 0) ? mq[0][31:0]  : 32'h0;
   endtask

   task automatic test_reset();
      InInstruction = 32'hDEADBEEF; InPCPlus4 = 32'h10; InValid = 1'b1;
      OutReady = 1'b1; Flush = 1'b0; Reset = 1'b1;
      repeat (3) @(posedge Clock);
      #1;
      mq.delete();
      total_cnt++;
      if (OutValid !== 1'b0 || InReady !== 1'b1 || Count !== 3'd0) $display("FAIL reset_ctrl: got valid=%b ready=%b count=%0d expected 0/1/0", OutValid, InReady, Count);
      else pass_cnt++;
      total_cnt++;
      if (OutInstruction !== 32'h0 || OutPCPlus4 !== 32'h0) $display("FAIL reset_data: got %h/%h expected 0/0", OutInstruction, OutPCPlus4);
      else pass_cnt++;
      InValid = 1'b0; OutReady = 1'b0;
      Reset = 1'b0;
      #2;
   endtask

   task automatic test_basic();
      step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      InInstruction = 32'h20080005; InPCPlus4 = 32'h4; InValid = 1'b1; OutReady = 1'b0; Flush = 1'b0;
      #1;
      total_cnt++;
      if (OutValid !== 1'b0) $display("FAIL no_fallthrough: got valid=%b expected 0", OutValid);
      else pass_cnt++;
      step(32'h20080005, 32'h4, 1'b1, 1'b0, 1'b0);
      total_cnt++;
      if (OutValid !== 1'b1 || OutInstruction !== 32'h20080005 || OutPCPlus4 !== 32'h4 || Count !== 3'd1)
         $display("FAIL basic_push: got valid=%b instr=%h pc=%h count=%0d expected 1/20080005/4/1", OutValid, OutInstruction, OutPCPlus4, Count);
      else pass_cnt++;
   endtask

   task automatic test_full();
      step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         step(32'h10000000 + 32'(k), 32'(4 * (k + 1)), 1'b1, 1'b0, 1'b0);
         if (k >= 3) begin
            total_cnt++;
            if (Count !== 3'd4 || InReady !== 1'b0) $display("FAIL full_push%0d: got count=%0d ready=%b expected 4/0", k, Count, InReady);
            else pass_cnt++;
         end
      end
      for (int k = 0; k < 4; k++) begin
         total_cnt++;
         if (OutInstruction !== 32'h10000000 + 32'(k) || OutPCPlus4 !== 32'(4 * (k + 1)))
            $display("FAIL drain_order%0d: got %h/%h expected %h/%h", k, OutInstruction, OutPCPlus4, 32'h10000000 + 32'(k), 32'(4 * (k + 1)));
         else pass_cnt++;
         step(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      end
      total_cnt++;
      if (Count !== 3'd0 || OutValid !== 1'b0 || OutInstruction !== 32'h0) $display("FAIL drain_empty: got count=%0d valid=%b instr=%h expected 0/0/0", Count, OutValid, OutInstruction);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      step(32'hA0000000, 32'h100, 1'b1, 1'b0, 1'b0);
      step(32'hA0000001, 32'h104, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         d = $urandom();
         step(d, 32'h200 + 32'(4 * k), 1'b1, 1'b1, 1'b0);
         model_expect();
         total_cnt++;
         if (Count !== 3'd2 || OutInstruction !== exp_instr || OutPCPlus4 !== exp_pc)
            $display("FAIL b2b%0d: got count=%0d head=%h/%h expected 2 %h/%h", k, Count, OutInstruction, OutPCPlus4, exp_instr, exp_pc);
         else pass_cnt++;
      end
   endtask

   task automatic test_flush();
      step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) step(32'hB0000000 + 32'(k), 32'h300 + 32'(k), 1'b1, 1'b0, 1'b0);
      step(32'hBBBBBBBB, 32'h3FC, 1'b1, 1'b1, 1'b1);
      total_cnt++;
      if (Count !== 3'd0 || OutValid !== 1'b0 || OutInstruction !== 32'h0 || InReady !== 1'b1)
         $display("FAIL flush: got count=%0d valid=%b instr=%h ready=%b expected 0/0/0/1", Count, OutValid, OutInstruction, InReady);
      else pass_cnt++;
      step(32'hC0000001, 32'h400, 1'b1, 1'b0, 1'b0);
      total_cnt++;
      if (OutInstruction !== 32'hC0000001 || Count !== 3'd1) $display("FAIL flush_after: got %h count=%0d expected c0000001 1", OutInstruction, Count);
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      step(32'hD0000000, 32'h500, 1'b1, 1'b0, 1'b0);
      step(32'hD0000001, 32'h504, 1'b1, 1'b0, 1'b0);
      InValid = 1'b0;
      #2 Reset = 1'b1;
      #1;
      total_cnt++;
      if (Count !== 3'd0 || OutValid !== 1'b0 || OutInstruction !== 32'h0) $display("FAIL async_reset: got count=%0d valid=%b instr=%h expected 0/0/0", Count, OutValid, OutInstruction);
      else pass_cnt++;
      #1 Reset = 1'b0;
      mq.delete();
      step(32'h8C090000, 32'h600, 1'b1, 1'b0, 1'b0);
      total_cnt++;
      if (OutInstruction !== 32'h8C090000 || OutPCPlus4 !== 32'h600 || Count !== 3'd1) $display("FAIL reset_head: got %h/%h count=%0d expected 8c090000/600/1", OutInstruction, OutPCPlus4, Count);
      else pass_cnt++;
   endtask

   task automatic test_empty_pop();
      step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step(32'hEEEEEEEE, 32'h700, 1'b0, 1'b1, 1'b0);
         total_cnt++;
         if (Count !== 3'd0 || OutValid !== 1'b0 || OutInstruction !== 32'h0 || OutPCPlus4 !== 32'h0)
            $display("FAIL empty_pop%0d: got count=%0d valid=%b head=%h/%h expected 0/0/0/0", k, Count, OutValid, OutInstruction, OutPCPlus4);
         else pass_cnt++;
      end
      step(32'hE0000001, 32'h704, 1'b1, 1'b0, 1'b0);
      step(32'hE0000002, 32'h708, 1'b1, 1'b1, 1'b0);
      total_cnt++;
      if (OutInstruction !== 32'hE0000002 || Count !== 3'd1) $display("FAIL empty_pop_resume: got %h count=%0d expected e0000002 1", OutInstruction, Count);
      else pass_cnt++;
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int k = 0; k < 400; k++) begin
         step($urandom(), $urandom(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 19) == 0));
         model_expect();
         total_cnt++;
         if (OutValid !== exp_valid || InReady !== exp_ready || Count !== exp_count ||
             OutInstruction !== exp_instr || OutPCPlus4 !== exp_pc) begin
            if (errs < 10)
               $display("FAIL random%0d: got v=%b r=%b c=%0d %h/%h expected v=%b r=%b c=%0d %h/%h", k,
                        OutValid, InReady, Count, OutInstruction, OutPCPlus4,
                        exp_valid, exp_ready, exp_count, exp_instr, exp_pc);
            errs++;
         end else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_empty_pop();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
